// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter for the core's data bus.
// TXDATA (offset 0) pushes a byte into a small TX FIFO; STATUS (offset 4)
// reports busy/full/empty/overflow/count and clears overflow on write.
// A serializer drains the FIFO as 8N1 frames on tx, back-to-back when data waits.
module mmio_uart_tx #(
    parameter int                     WORD_LEN   = 32,
    parameter logic [WORD_LEN-1:0]    BASE_ADDR  = WORD_LEN'(32'hFFFF_FF00),
    parameter int                     CLK_DIV    = 234,
    parameter int                     FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                wen,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata,
    output logic                sel,
    output logic                tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [CW-1:0]       DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0]       DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [WORD_LEN-1:0] STATUS_ADDR = BASE_ADDR + WORD_LEN'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            pop;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic            hit_tx, hit_st;
    logic            full, empty, busy;
    logic            push_req, do_push;
    logic            div_end;
    logic [7:0]      head;
    logic [WORD_LEN-1:0] status;

    // Upper write-data bits carry no meaning for TXDATA.
    logic            unused_wdata;
    assign unused_wdata = ^wdata[WORD_LEN-1:8];

    assign hit_tx   = (d_addr == BASE_ADDR);
    assign hit_st   = (d_addr == STATUS_ADDR);
    assign sel      = hit_tx | hit_st;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign push_req = wen & hit_tx;
    // A full FIFO rejects the byte even if the serializer pops this cycle.
    assign do_push  = push_req & ~full;
    assign head     = mem[rd_ptr];
    assign div_end  = (div_q == DIV_LAST);
    assign tx       = tx_q;

    // Assemble STATUS and drive read data combinationally from current state.
    always_comb begin
        status       = '0;
        status[0]    = busy;
        status[1]    = full;
        status[2]    = empty;
        status[3]    = overflow_q;
        status[15:8] = 8'(count_q);
        rdata        = hit_st ? status : '0;
    end

    // FIFO storage: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wen && hit_st) begin
                overflow_q <= 1'b0;
            end else if (push_req && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Serializer next-state: each phase lasts CLK_DIV cycles, stop chains into start.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DATA: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STOP: begin
                if (div_end) begin
                    div_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Serializer control registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    // Shift register holds the byte in flight; its contents are don't-care when idle.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed scenarios plus a random phase.
// A frame-level model predicts which bytes are accepted and when each frame
// starts; a line decoder samples tx mid-bit and compares against the model queue.
module tb_mmio_uart_tx;

    localparam int          CLK_DIV = 4;
    localparam int          DEPTH   = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [31:0] BASE    = 32'hFFFF_FF00;
    localparam logic [31:0] ST      = 32'hFFFF_FF04;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mmio_uart_tx #(
        .WORD_LEN  (32),
        .BASE_ADDR (BASE),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d_addr(d_addr),
        .wen   (wen),
        .wdata (wdata),
        .rdata (rdata),
        .sel   (sel),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_q[$];     // bytes waiting in the FIFO
    logic [7:0] exp_q[$];   // frames expected on the line, in order
    int         m_rem = 0;  // cycles left in the frame on the line
    logic       m_ovf = 1'b0;
    int         m_sz;
    logic       m_can_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
        end else begin
            m_sz = m_q.size();
            if (m_rem > 0) m_rem--;
            m_can_pop = (m_rem == 0) && (m_sz > 0);
            if (wen && d_addr == ST) m_ovf = 1'b0;
            if (wen && d_addr == BASE) begin
                if (m_sz == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(wdata[7:0]);
            end
            if (m_can_pop) begin
                exp_q.push_back(m_q.pop_front());
                m_rem = FRAME;
            end
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_rem > 0);
        s[1]     = (m_q.size() == DEPTH);
        s[2]     = (m_q.size() == 0);
        s[3]     = m_ovf;
        s[15:8]  = 8'(m_q.size());
        return s;
    endfunction

    // ---------------- tx line decoder / scoreboard monitor ----------------
    logic       d_act = 1'b0;
    int         d_cnt = 0;
    int         d_j;
    logic       d_ok;
    logic [7:0] d_byte;
    logic [7:0] d_exp;
    int         frames_rx = 0;
    int         starts_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (tx === 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
                d_ok  = 1'b1;
                starts_q.push_back(cyc);
            end
        end else begin
            d_cnt++;
        end
        if (d_act && rst_n) begin
            if (d_cnt % CLK_DIV == CLK_DIV / 2) begin
                d_j = d_cnt / CLK_DIV;
                if (d_j == 0) begin
                    if (tx !== 1'b0) d_ok = 1'b0;
                end else if (d_j <= 8) begin
                    d_byte[d_j-1] = tx;
                end else begin
                    if (tx !== 1'b1) d_ok = 1'b0;
                    checks++;
                    frames_rx++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: got %02h, no frame expected", d_byte);
                    end else begin
                        d_exp = exp_q.pop_front();
                        if (!d_ok || d_byte !== d_exp) begin
                            errors++;
                            $display("FAIL frame: got %02h framing_ok=%0d, expected %02h framing_ok=1",
                                     d_byte, d_ok, d_exp);
                        end
                    end
                end
            end
            if (d_cnt == FRAME - 1) d_act = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] dat);
        @(posedge clk);
        #1;
        d_addr = a;
        wen    = w;
        wdata  = dat;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_s,
                      input string name);
        bus(a, 1'b0, 32'h0);
        @(negedge clk);
        check({name, ".rdata"}, rdata, exp_d);
        check({name, ".sel"}, {31'b0, sel}, {31'b0, exp_s});
    endtask

    int          busy_cyc;
    int          max_cnt;
    int          cnt_at10;
    logic [31:0] last_st;

    // Read STATUS every cycle against the model until the model has drained.
    task automatic poll(input int limit, input string name);
        logic done;
        done     = 1'b0;
        busy_cyc = 0;
        max_cnt  = 0;
        cnt_at10 = -1;
        for (int i = 0; i < limit; i++) begin
            bus(ST, 1'b0, 32'h0);
            @(negedge clk);
            check({name, ".status"}, rdata, model_status());
            last_st = rdata;
            if (rdata[0]) busy_cyc++;
            if (int'(rdata[15:8]) > max_cnt) max_cnt = int'(rdata[15:8]);
            if (i == 10) cnt_at10 = int'(rdata[15:8]);
            if (m_rem == 0 && m_q.size() == 0 && exp_q.size() == 0 && !d_act) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: still active after %0d cycles, required idle", name, limit);
        end
    endtask

    int          f0;
    int          tx_low;
    logic [31:0] bad;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        d_addr = 32'h0;
        wen    = 1'b0;
        wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.tx", {31'b0, tx}, 32'h1);
        rst_n = 1'b1;

        // Reset state and decode
        rd(ST, 32'h0000_0004, 1'b1, "reset.status");
        check("reset.tx_idle", {31'b0, tx}, 32'h1);
        rd(32'h0, 32'h0, 1'b0, "addr0");
        rd(BASE, 32'h0, 1'b1, "txdata_read");

        // Single frame 0x55
        f0 = frames_rx;
        bus(BASE, 1'b1, 32'hFFFF_FF55);
        poll(200, "single");
        check("single.busy_cycles", busy_cyc, 40);
        check("single.frames", frames_rx - f0, 1);
        rd(ST, 32'h0000_0004, 1'b1, "single.final");

        // Two back-to-back frames
        f0 = frames_rx;
        starts_q.delete();
        bus(BASE, 1'b1, 32'h41);
        bus(BASE, 1'b1, 32'h42);
        poll(300, "pair");
        check("pair.busy_cycles", busy_cyc, 80);
        check("pair.count_mid_first", cnt_at10, 1);
        check("pair.frames", frames_rx - f0, 2);
        check("pair.starts", starts_q.size(), 2);
        if (starts_q.size() == 2) check("pair.start_gap", starts_q[1] - starts_q[0], FRAME);

        // Overflow: six bytes, five frames
        f0 = frames_rx;
        for (int i = 0; i < 6; i++) bus(BASE, 1'b1, 32'h10 + i);
        poll(500, "ovf");
        check("ovf.max_count", max_cnt, DEPTH);
        check("ovf.flag", {31'b0, last_st[3]}, 32'h1);
        check("ovf.frames", frames_rx - f0, 5);
        bus(ST, 1'b1, 32'h1234_5678);
        rd(ST, 32'h0000_0004, 1'b1, "ovf.cleared");

        // Reset in the middle of a data phase with two bytes queued
        f0 = frames_rx;
        bus(BASE, 1'b1, 32'h00);
        bus(BASE, 1'b1, 32'h5A);
        bus(BASE, 1'b1, 32'h3C);
        repeat (14) bus(32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("midreset.status_before", {24'b0, dut.rdata[7:0] | 8'h0}, 32'h0);
        check("midreset.tx_low", {31'b0, tx}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("midreset.tx_async", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        rd(ST, 32'h0000_0004, 1'b1, "midreset.status_after");
        tx_low = 0;
        for (int i = 0; i < 100; i++) begin
            bus(32'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("midreset.tx_quiet", tx_low, 0);
        check("midreset.frames", frames_rx - f0, 0);

        // Writes to unselected addresses
        f0 = frames_rx;
        bus(BASE + 32'h8, 1'b1, 32'hAB);
        @(negedge clk);
        check("bad8.sel", {31'b0, sel}, 32'h0);
        check("bad8.rdata", rdata, 32'h0);
        bus(BASE + 32'h2, 1'b1, 32'hAB);
        @(negedge clk);
        check("bad2.sel", {31'b0, sel}, 32'h0);
        tx_low = 0;
        for (int i = 0; i < 60; i++) begin
            bus(32'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("bad.tx_quiet", tx_low, 0);
        check("bad.frames", frames_rx - f0, 0);
        rd(ST, 32'h0000_0004, 1'b1, "bad.status");

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: bus(BASE, 1'b1, $urandom);
                3:       bus(ST, 1'b1, $urandom);
                4: begin
                    case ($urandom_range(0, 4))
                        0:       bad = BASE + 32'h1;
                        1:       bad = BASE + 32'h2;
                        2:       bad = BASE + 32'h3;
                        3:       bad = BASE + 32'h8;
                        default: bad = BASE - 32'h4;
                    endcase
                    bus(bad, 1'b1, $urandom);
                end
                default: begin
                    bus(ST, 1'b0, 32'h0);
                    @(negedge clk);
                    check("rand.status", rdata, model_status());
                end
            endcase
        end
        poll(1000, "drain");
        check("drain.exp_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
